// File: rtl/hrfp_mult_result_queue.sv
`default_nettype none
// ============================================================================
// Module  : hrfp_mult_result_queue
// Brief   : Credit-based flow control around a free-running fixed-latency
//           HRFP multiplier, with a FWFT result FIFO and back-pressure.
// Revision: 1.0  initial release
// ============================================================================
module hrfp_mult_result_queue #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 8,
  parameter int DEPTH    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] mult_op_a,
  output logic [WIDTH-1:0] mult_op_b,
  input  logic [WIDTH-1:0] mult_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             overflow_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [MULT_LAT-1:0] vld;
  logic [CW-1:0]       cred;
  logic [CW-1:0]       cred_nxt;
  logic                ready_q;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic                accept;
  logic                pop;
  logic                wr_en;
  logic                empty;
  logic                full;

  assign mult_op_a = in_a;
  assign mult_op_b = in_b;

  assign in_ready  = ready_q;
  assign accept    = in_valid & ready_q;
  assign pop       = out_valid & out_ready;
  assign wr_en     = vld[MULT_LAT-1];

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = ~empty;
  assign out_result = mem[rd_ptr[AW-1:0]];

  // Token line: one bit per multiplier stage marks a result worth keeping.
  generate
    if (MULT_LAT == 1) begin : g_vld_single
      always_ff @(posedge clk) begin
        if (rst) vld <= '0;
        else     vld <= accept;
      end
    end else begin : g_vld_chain
      always_ff @(posedge clk) begin
        if (rst) vld <= '0;
        else     vld <= {vld[MULT_LAT-2:0], accept};
      end
    end
  endgenerate

  always_comb begin
    cred_nxt = cred;
    if (accept && !pop)      cred_nxt = cred - CW'(1);
    else if (pop && !accept) cred_nxt = cred + CW'(1);
  end

  // in_ready is registered from the next credit value so it never depends
  // combinationally on in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      cred         <= CW'(DEPTH);
      ready_q      <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      cred    <= cred_nxt;
      ready_q <= (cred_nxt != '0);
      if (wr_en && !full) wr_ptr <= wr_ptr + PW'(1);
      if (pop)            rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && full)  overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= mult_result;
  end

endmodule
`default_nettype wire

// File: tb/tb_hrfp_mult_result_queue.sv
`default_nettype none
// Testbench for hrfp_mult_result_queue: delay-line multiplier stub (a^b),
// queue-based reference model, directed tables and randomized traffic.
module tb_hrfp_mult_result_queue;

  localparam int W  = 32;
  localparam int L  = 8;
  localparam int D  = 16;
  localparam int PW = $clog2(D) + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] mult_op_a;
  logic [W-1:0] mult_op_b;
  logic [W-1:0] mult_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         overflow_err;

  hrfp_mult_result_queue #(.WIDTH(W), .MULT_LAT(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_op_a(mult_op_a), .mult_op_b(mult_op_b), .mult_result(mult_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Free-running multiplier stand-in: L register stages of op_a ^ op_b.
  logic [W-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= mult_op_a ^ mult_op_b;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mult_result = pipe[L-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: each accepted op becomes visible after its write edge.
  typedef struct { logic [W-1:0] v; int wedge; } ent_t;
  ent_t q[$];
  logic last_acc;
  logic last_pop;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp; } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] occ();
    return dut.wr_ptr - dut.rd_ptr;
  endfunction

  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy);
    logic exp_rdy, exp_vld;
    int   inv;
    in_valid = iv; in_a = a; in_b = b; out_ready = ordy;
    #1;
    exp_rdy = (q.size() < D);
    exp_vld = (q.size() > 0) && (q[0].wedge < cyc);
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    chk("out_valid", W'(out_valid), W'(exp_vld));
    if (exp_vld) chk("out_result", out_result, q[0].v);
    chk("overflow_err", W'(overflow_err), '0);
    inv = int'(dut.cred) + $countones(dut.vld) + int'(occ());
    chk("credit_invariant", W'(inv), W'(D));
    last_acc = iv & exp_rdy;
    last_pop = ordy & exp_vld;
    if (last_pop) void'(q.pop_front());
    if (last_acc) q.push_back('{a ^ b, cyc + L});
    @(posedge clk); cyc++; #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); cyc++; #1;
    rst = 1'b0;
    q.delete();
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_cred", W'(dut.cred), W'(D));
    chk("rst_overflow", W'(overflow_err), W'(0));
  endtask

  initial begin
    int n, nacc, npop;
    tbl[0] = '{32'h3,        32'h5,        32'h6};
    tbl[1] = '{32'h9,        32'h1,        32'h8};
    tbl[2] = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF};
    tbl[3] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};

    // Single-op latency and result per table entry.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      step(1'b1, tbl[i].a, tbl[i].b, 1'b1);
      n = 0;
      while (n < 40) begin
        if (out_valid) break;
        step(1'b0, '0, '0, 1'b0);
        n++;
      end
      chk("tbl_latency", W'(n), W'(L));
      chk("tbl_result", out_result, tbl[i].exp);
      step(1'b0, '0, '0, 1'b1);
      chk("tbl_cred_back", W'(dut.cred), W'(D));
    end

    // Sustained back-to-back throughput.
    do_reset();
    npop = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, $urandom, $urandom, 1'b1);
      npop += int'(last_pop);
    end
    for (int i = 0; i < L + 4; i++) begin
      step(1'b0, '0, '0, 1'b1);
      npop += int'(last_pop);
    end
    chk("t2_pops", W'(npop), W'(100));

    // Back-pressure: exactly D accepts then stall, then drain in order.
    do_reset();
    nacc = 0;
    for (int i = 0; i < D + L; i++) begin
      step(1'b1, $urandom, $urandom, 1'b0);
      nacc += int'(last_acc);
    end
    chk("t3_accepts", W'(nacc), W'(D));
    chk("t3_stalled", W'(in_ready), W'(0));
    chk("t3_full_occ", W'(occ()), W'(D));
    chk("t3_out_valid", W'(out_valid), W'(1));
    npop = 0;
    for (int i = 0; i < D + 4; i++) begin
      step(1'b0, '0, '0, 1'b1);
      npop += int'(last_pop);
    end
    chk("t3_drained", W'(npop), W'(D));

    // Zero credit with tokens in flight: pop while a write lands.
    do_reset();
    for (int i = 0; i < D + 1; i++) step(1'b1, $urandom, $urandom, 1'b0);
    chk("t6_cred0", W'(dut.cred), W'(0));
    chk("t6_occ_before", W'(occ()), W'(9));
    step(1'b1, $urandom, $urandom, 1'b1);
    chk("t6_occ_pop_write", W'(occ()), W'(9));
    chk("t6_cred_after_pop", W'(dut.cred), W'(1));
    step(1'b1, $urandom, $urandom, 1'b1);
    chk("t6_acc_and_pop_cred", W'(dut.cred), W'(1));
    chk("t6_occ_acc_pop", W'(occ()), W'(9));
    for (int i = 0; i < 40; i++) step(1'b0, '0, '0, 1'b1);

    // Reset with 5 tokens in flight and 3 results queued.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0);
    chk("t5_queued", W'(occ()), W'(3));
    chk("t5_inflight", W'($countones(dut.vld)), W'(5));
    do_reset();
    for (int i = 0; i < L + 4; i++) step(1'b0, '0, '0, 1'b1);
    step(1'b1, 32'h9, 32'h1, 1'b1);
    n = 0;
    while (n < 40) begin
      if (out_valid) break;
      step(1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("t5_latency", W'(n), W'(L));
    chk("t5_result", out_result, 32'h8);
    step(1'b0, '0, '0, 1'b1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 10000; i++)
      step(logic'($urandom_range(0, 99) < 50), $urandom, $urandom,
           logic'($urandom_range(0, 99) < 30));
    for (int i = 0; i < D + L + 8; i++) step(1'b0, '0, '0, 1'b1);
    chk("t4_all_drained", W'(occ()), W'(0));
    chk("t4_overflow", W'(overflow_err), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
